sccb_slave_responder: RTL

//  SCCB/I2C target (responder) for the camera-config bus: decodes START/STOP, device

---
 rtl/sccb_slave_responder_if.sv | 16 +
 rtl/sccb_slave_responder.sv | 139 +++++++++++++
 2 files changed

// File: rtl/sccb_slave_responder_if.sv
// sccb_slave_responder_if: SCCB bus pins plus the register-file port of the responder.
interface sccb_slave_responder_if;
  logic       scl;
  logic       sda_in;
  logic       sda_oe;
  logic       reg_we;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic [7:0] reg_rdata;
  logic       busy;
  logic       nack_err;
  modport slave (input scl, sda_in, reg_rdata,
                 output sda_oe, reg_we, reg_addr, reg_wdata, busy, nack_err);
  modport master (output scl, sda_in, reg_rdata,
                  input sda_oe, reg_we, reg_addr, reg_wdata, busy, nack_err);
endinterface

// File: rtl/sccb_slave_responder.sv
// sccb_slave_responder: SCCB/I2C target that ACKs writes into a register file and serves reads.
module sccb_slave_responder #(
  parameter logic [6:0] DEV_ADDR    = 7'h21,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  sccb_slave_responder_if.slave bus
);
  typedef enum logic [3:0] {IDLE, DEV, ACK_DEV, SUB, ACK_SUB, WDAT, ACK_W, RDAT, MACK, WAIT_STOP} state_t;
  state_t r_state, w_state_n;
  logic [SYNC_STAGES-1:0] r_scl_s, r_sda_s;
  logic r_scl_d, r_sda_d;
  logic w_scl, w_sda, w_rise, w_fall, w_start, w_stop, w_last;
  logic [7:0] w_byte, r_addr, r_wdata;
  logic [6:0] r_shift;
  logic [2:0] r_bit;
  logic r_oe, r_we, r_nack_err, r_rw, r_mack, r_rd_nack;
  assign w_scl   = r_scl_s[SYNC_STAGES-1];
  assign w_sda   = r_sda_s[SYNC_STAGES-1];
  assign w_rise  = w_scl & ~r_scl_d;
  assign w_fall  = ~w_scl & r_scl_d;
  assign w_start = w_scl & r_scl_d & r_sda_d & ~w_sda;
  assign w_stop  = w_scl & r_scl_d & ~r_sda_d & w_sda;
  assign w_byte  = {r_shift, w_sda};
  assign w_last  = r_bit == 3'd7;
  // Synchronisers reset to the idle-high bus level so release of reset creates no START.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_scl_s <= '1;
      r_sda_s <= '1;
      r_scl_d <= 1'b1;
      r_sda_d <= 1'b1;
      r_state <= IDLE;
    end else begin
      r_scl_s <= {r_scl_s[SYNC_STAGES-2:0], bus.scl};
      r_sda_s <= {r_sda_s[SYNC_STAGES-2:0], bus.sda_in};
      r_scl_d <= w_scl;
      r_sda_d <= w_sda;
      r_state <= w_state_n;
    end
  end
  always_comb begin
    w_state_n = r_state;
    if (w_stop) w_state_n = IDLE;
    else if (w_start) w_state_n = DEV;
    else
      case (r_state)
        DEV:     if (w_rise && w_last) w_state_n = (w_byte[7:1] == DEV_ADDR) ? ACK_DEV : WAIT_STOP;
        SUB:     if (w_rise && w_last) w_state_n = ACK_SUB;
        WDAT:    if (w_rise && w_last) w_state_n = ACK_W;
        ACK_DEV: if (w_fall && r_oe) w_state_n = r_rw ? RDAT : SUB;
        ACK_SUB, ACK_W: if (w_fall && r_oe) w_state_n = WDAT;
        RDAT:    if (w_rise && w_last) w_state_n = MACK;
        MACK:    w_state_n = (w_rise && w_sda) ? WAIT_STOP : (w_fall && r_mack) ? RDAT : MACK;
        default: w_state_n = r_state;
      endcase
  end
  // In ACK states r_oe doubles as the phase flag: first SCL fall drives, second releases.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_oe       <= 1'b0;
      r_we       <= 1'b0;
      r_nack_err <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_shift    <= '0;
      r_bit      <= '0;
      r_rw       <= 1'b0;
      r_mack     <= 1'b0;
      r_rd_nack  <= 1'b0;
    end else begin
      r_we       <= 1'b0;
      r_nack_err <= 1'b0;
      if (w_stop) begin
        r_oe      <= 1'b0;
        r_bit     <= '0;
        r_mack    <= 1'b0;
        r_rd_nack <= 1'b0;
      end else if (w_start) begin
        r_bit      <= '0;
        r_mack     <= 1'b0;
        r_rd_nack  <= 1'b0;
        r_nack_err <= r_rd_nack;
      end else
        case (r_state)
          DEV, SUB, WDAT: begin
            if (w_rise) begin
              r_shift <= w_byte[6:0];
              r_bit   <= r_bit + 3'd1;
              if (w_last && r_state == DEV) r_rw <= w_byte[0];
              if (w_last && r_state == SUB) r_addr <= w_byte;
              if (w_last && r_state == WDAT) begin
                r_we    <= 1'b1;
                r_wdata <= w_byte;
              end
            end
            if (w_fall) r_oe <= 1'b0;
          end
          ACK_DEV, ACK_SUB, ACK_W: if (w_fall) begin
            r_oe <= ~r_oe;
            if (!r_oe && r_state == ACK_W) r_addr <= r_addr + 8'd1;
            if (r_oe && r_state == ACK_DEV && r_rw) begin
              r_shift <= bus.reg_rdata[6:0];
              r_oe    <= ~bus.reg_rdata[7];
            end
          end
          RDAT: begin
            if (w_rise) begin
              r_bit <= r_bit + 3'd1;
              if (w_last) r_addr <= r_addr + 8'd1;
            end
            if (w_fall) begin
              r_shift <= {r_shift[5:0], 1'b0};
              r_oe    <= ~r_shift[6];
            end
          end
          MACK: begin
            if (w_rise) begin
              r_rd_nack <= w_sda;
              r_mack    <= ~w_sda;
            end
            if (w_fall) begin
              r_mack  <= 1'b0;
              r_shift <= bus.reg_rdata[6:0];
              r_oe    <= r_mack & ~bus.reg_rdata[7];
            end
          end
          default: if (w_fall) r_oe <= 1'b0;
        endcase
    end
  end
  assign bus.sda_oe    = r_oe;
  assign bus.reg_we    = r_we;
  assign bus.reg_addr  = r_addr;
  assign bus.reg_wdata = r_wdata;
  assign bus.busy      = r_state != IDLE;
  assign bus.nack_err  = r_nack_err;
endmodule
